// File: rtl/door_controller_timed.sv
// door_controller_timed: garage/gate door controller with reset-time homing,
// Activate rising-edge detection, motor-run timeout fault, obstruction
// reversal while closing and an optional auto-close from OPEN.
// Optional feature macro: DOOR_AUTO_CLOSE_EN (OPEN closes itself after
// HOLD_CYCLES unobstructed cycles). Without it, OPEN is left only by a
// button press or a sensor conflict.
module door_controller_timed #(
    parameter int CNT_W        = 16,
    parameter int MOVE_TIMEOUT = 1000,
    parameter int HOLD_CYCLES  = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       Up_Max,
    input  logic       Dn_Max,
    input  logic       Obstruct,
    input  logic       Fault_Clr,
    output logic       Up_M,
    output logic       Dn_M,
    output logic       Fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLOSED = 3'd1,
        MV_UP  = 3'd2,
        OPEN   = 3'd3,
        MV_DN  = 3'd4,
        FAULT  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

`ifdef DOOR_AUTO_CLOSE_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`else
    // HOLD_CYCLES only matters when auto-close is built in.
    logic unused_hold_s;
    assign unused_hold_s = ^CNT_W'(HOLD_CYCLES);
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             act_q;
    logic             act_edge_s;
    logic             conflict_s;
    logic             move_last_s;

    assign act_edge_s  = Activate & ~act_q;
    assign conflict_s  = Up_Max & Dn_Max;
    assign move_last_s = (timer_q == MOVE_LAST);

    // Next-state selection with per-state priority; sensor conflict wins everywhere but FAULT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (conflict_s)       state_d = FAULT;
                else if (Dn_Max)      state_d = CLOSED;
                else if (Up_Max)      state_d = OPEN;
                else                  state_d = MV_DN;   // homing toward closed
            end
            CLOSED: begin
                if (conflict_s)       state_d = FAULT;
                else if (act_edge_s)  state_d = MV_UP;
                else                  state_d = CLOSED;
            end
            MV_UP: begin
                // End sensor checked before timeout so arrival on the last cycle is not a fault.
                if (conflict_s)       state_d = FAULT;
                else if (Up_Max)      state_d = OPEN;
                else if (move_last_s) state_d = FAULT;
                else                  state_d = MV_UP;
            end
            OPEN: begin
                if (conflict_s)       state_d = FAULT;
                else if (Obstruct)    state_d = OPEN;    // never start closing into a blocked doorway
                else if (act_edge_s)  state_d = MV_DN;
`ifdef DOOR_AUTO_CLOSE_EN
                else if (timer_q == HOLD_LAST) state_d = MV_DN;
`endif
                else                  state_d = OPEN;
            end
            MV_DN: begin
                if (conflict_s)       state_d = FAULT;
                else if (Dn_Max)      state_d = CLOSED;
                else if (Obstruct)    state_d = MV_UP;   // reversal
                else if (move_last_s) state_d = FAULT;
                else if (act_edge_s)  state_d = MV_UP;
                else                  state_d = MV_DN;
            end
            FAULT: begin
                if (Fault_Clr)        state_d = IDLE;    // re-home after clearing
                else                  state_d = FAULT;
            end
            default: begin
                state_d = IDLE;                          // unused codes recover
            end
        endcase
    end

    // Shared timer: restarts on any state change, counts in timed states, saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == OPEN) && Obstruct) begin
            timer_d = '0;
        end else if ((state_q == MV_UP) || (state_q == MV_DN) || (state_q == OPEN)) begin
            if (timer_q != TIMER_MAX) timer_d = timer_q + CNT_W'(1);
            else                      timer_d = timer_q;
        end else begin
            timer_d = '0;
        end
    end

    // State, timer and button-history registers; button assumed held during reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            timer_q <= '0;
            act_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            act_q   <= Activate;
        end
    end

    // Registered outputs, each a decode of the state being loaded into state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Up_M  <= 1'b0;
            Dn_M  <= 1'b0;
            Fault <= 1'b0;
            State <= 3'd0;
        end else begin
            Up_M  <= (state_d == MV_UP);
            Dn_M  <= (state_d == MV_DN);
            Fault <= (state_d == FAULT);
            State <= state_d;
        end
    end

endmodule

// File: tb/tb_door_controller_timed.sv
// Directed testbench for door_controller_timed (MOVE_TIMEOUT=8, HOLD_CYCLES=5).
// Honours DOOR_AUTO_CLOSE_EN for the auto-close expectations.
module tb_door_controller_timed;

    logic       CLK;
    logic       RST;
    logic       Activate;
    logic       Up_Max;
    logic       Dn_Max;
    logic       Obstruct;
    logic       Fault_Clr;
    logic       Up_M;
    logic       Dn_M;
    logic       Fault;
    logic [2:0] State;

    int n_checks = 0;
    int n_errors = 0;

    door_controller_timed #(
        .CNT_W       (16),
        .MOVE_TIMEOUT(8),
        .HOLD_CYCLES (5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Activate (Activate),
        .Up_Max   (Up_Max),
        .Dn_Max   (Dn_Max),
        .Obstruct (Obstruct),
        .Fault_Clr(Fault_Clr),
        .Up_M     (Up_M),
        .Dn_M     (Dn_M),
        .Fault    (Fault),
        .State    (State)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle outputs.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st,
                              input logic up, input logic dn, input logic flt);
        check({tag, ".state"}, {29'd0, State}, {29'd0, st});
        check({tag, ".up"},    {31'd0, Up_M},  {31'd0, up});
        check({tag, ".dn"},    {31'd0, Dn_M},  {31'd0, dn});
        check({tag, ".fault"}, {31'd0, Fault}, {31'd0, flt});
        check({tag, ".onehot"}, {31'd0, Up_M & Dn_M}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; Activate = 1'b0; Up_Max = 1'b0; Dn_Max = 1'b1;
        Obstruct = 1'b0; Fault_Clr = 1'b0;

        // Reset, door closed.
        tick(); tick();
        expect_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        expect_all("rst_release", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all("home_closed", 3'd1, 1'b0, 1'b0, 1'b0);

        // Open with button held; Up_Max arrives on the 4th cycle.
        Activate = 1'b1;
        tick(); expect_all("mvup1", 3'd2, 1'b1, 1'b0, 1'b0);
        Dn_Max = 1'b0;
        tick(); expect_all("mvup2", 3'd2, 1'b1, 1'b0, 1'b0);
        tick(); expect_all("mvup3", 3'd2, 1'b1, 1'b0, 1'b0);
        Up_Max = 1'b1;
        tick(); expect_all("opened", 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_all("held_no_move", 3'd3, 1'b0, 1'b0, 1'b0);
        end
        Activate = 1'b0;
        tick(); expect_all("open_release", 3'd3, 1'b0, 1'b0, 1'b0);

        // Close, then obstruction reversal.
        Activate = 1'b1;
        tick(); expect_all("mvdn", 3'd4, 1'b0, 1'b1, 1'b0);
        Activate = 1'b0; Up_Max = 1'b0;
        tick(); tick();
        expect_all("mvdn_run", 3'd4, 1'b0, 1'b1, 1'b0);
        Obstruct = 1'b1;
        tick(); expect_all("reverse", 3'd2, 1'b1, 1'b0, 1'b0);
        Obstruct = 1'b0;

        // Timer restarted at reversal: motor up exactly 8 cycles then FAULT.
        for (int i = 1; i < 8; i++) begin
            tick(); expect_all("timeout_run", 3'd2, 1'b1, 1'b0, 1'b0);
        end
        tick(); expect_all("timeout_fault", 3'd5, 1'b0, 1'b0, 1'b1);
        tick(); expect_all("fault_stays", 3'd5, 1'b0, 1'b0, 1'b1);

        // Clear fault, home downward, land closed.
        Fault_Clr = 1'b1;
        tick(); expect_all("clr_idle", 3'd0, 1'b0, 1'b0, 1'b0);
        Fault_Clr = 1'b0;
        tick(); expect_all("homing_dn", 3'd4, 1'b0, 1'b1, 1'b0);
        Dn_Max = 1'b1;
        tick(); expect_all("homed", 3'd1, 1'b0, 1'b0, 1'b0);

        // Sensor conflict in CLOSED.
        Up_Max = 1'b1;
        tick(); expect_all("conflict_closed", 3'd5, 1'b0, 1'b0, 1'b1);

        // Sensor conflict beats Up_Max in MV_UP.
        Fault_Clr = 1'b1; Up_Max = 1'b0;
        tick(); tick();
        expect_all("back_closed", 3'd1, 1'b0, 1'b0, 1'b0);
        Fault_Clr = 1'b0; Activate = 1'b1;
        tick(); expect_all("mvup_b", 3'd2, 1'b1, 1'b0, 1'b0);
        Activate = 1'b0; Dn_Max = 1'b0;
        tick();
        Up_Max = 1'b1; Dn_Max = 1'b1;
        tick(); expect_all("conflict_mvup", 3'd5, 1'b0, 1'b0, 1'b1);

        // Up_Max on the timeout cycle: end sensor wins.
        Fault_Clr = 1'b1; Up_Max = 1'b0;
        tick();
        Fault_Clr = 1'b0;
        tick(); expect_all("closed_c", 3'd1, 1'b0, 1'b0, 0);
        Activate = 1'b1;
        tick();
        Activate = 1'b0; Dn_Max = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        expect_all("at_last_cycle", 3'd2, 1'b1, 1'b0, 1'b0);
        Up_Max = 1'b1;
        tick(); expect_all("end_beats_timeout", 3'd3, 1'b0, 1'b0, 1'b0);

        // Obstruct in OPEN holds the door and masks the button.
        Obstruct = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Activate = (i == 3);
            tick(); expect_all("open_obstructed", 3'd3, 1'b0, 1'b0, 1'b0);
        end
        Activate = 1'b0; Obstruct = 1'b0;
`ifdef DOOR_AUTO_CLOSE_EN
        for (int i = 0; i < 4; i++) begin
            tick(); expect_all("hold_open", 3'd3, 1'b0, 1'b0, 1'b0);
        end
        tick(); expect_all("auto_close", 3'd4, 1'b0, 1'b1, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            tick(); expect_all("no_auto_close", 3'd3, 1'b0, 1'b0, 1'b0);
        end
        Activate = 1'b1;
        tick(); expect_all("manual_close", 3'd4, 1'b0, 1'b1, 1'b0);
`endif

        // Reset mid-motion with button held: motors stop, held button is not an edge.
        Up_Max = 1'b0; Activate = 1'b1; RST = 1'b1;
        tick(); expect_all("rst_motion", 3'd0, 1'b0, 1'b0, 1'b0);
        Dn_Max = 1'b1; RST = 1'b0;
        tick(); expect_all("rst_home", 3'd1, 1'b0, 1'b0, 1'b0);
        tick(); expect_all("held_btn_no_edge", 3'd1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
